md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
// - Multiply/divide unit in the EX stage, beside the ALU. It takes the same SrcA/SrcB operands from the ID/EX register.
// - mdu_result is muxed with ALUresult into the EX/MEM result field.
// - Owns the HI/LO registers and implements MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
// - Multi-cycle: asserts busy so hazard control stalls later MD instructions.
// PARAMETERS
// - MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
// - DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
// - clk         in   1   single clock, rising edge
// - reset       in   1   synchronous, active-high; clears all state
// - valid       in   1   EX-stage instruction is real (not a bubble); qualifies every op
// - mdu_op      in   4   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO
// - SrcA        in   32  rs value (multiplicand/dividend, MTHI/MTLO data)
// - SrcB        in   32  rt value (multiplier/divisor)
// - busy        out  1   operation in flight
// - HI          out  32  architectural HI
// - LO          out  32  architectural LO
// - mdu_result  out  32  MFHI: HI; MFLO: LO; else 0 (combinational)
// BEHAVIOUR
// - Reset values: busy=0, HI=0, LO=0, internal counter=0, pending regs=0.
//   mdu_result follows mdu_op/HI/LO.
// - Start condition:
//   - valid && !busy && mdu_op in {MULT,MULTU,DIV,DIVU}.
//   - On that edge, latch the computed {hi,lo} into pending regs.
//   - Load cnt with MULT_CYCLES or DIV_CYCLES; set busy=1.
// - While busy, each edge decrements cnt. On the edge where cnt==1:
//   - HI/LO <= pending;
//   - busy <= 0, cnt <= 0.
//   - Net effect: busy is high for exactly N cycles; new HI/LO are visible in the first cycle busy is low.
// - Arithmetic:
//   - MULT: {HI,LO} = $signed(A) * $signed(B), 64-bit.
//   - MULTU: same product, unsigned.
//   - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
//   - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
//   - DIVU: unsigned quotient and remainder.
//   - Divisor 0 (DIV/DIVU): HI/LO keep prior values at commit. busy timing is unchanged (DIV_CYCLES).
// - MTHI/MTLO:
//   - When valid && !busy, HI (resp. LO) <= SrcA on the edge; visible next cycle.
//   - No busy is raised.
// - Reads: MFHI/MFLO return the current HI/LO combinationally. Hazard control guarantees no read while busy.
// - Ops presented while busy (start, MTHI, MTLO): ignored, with no state change. Hazard control must stall them;
//   md_unit does not queue.
// - valid=0 or mdu_op NONE: no state change.
// - reset mid-operation: busy, cnt, pending, HI and LO all go to 0 on that edge. The in-flight result is discarded.
// - reset and start on the same edge: reset wins.
// STRUCTURE
// - Shared constants header (cpu_defs.vh): MDU_* op encodings (4-bit). Hazard control and decode use the same header.
// - One combinational sub-module, md_calc(op, A, B, prev_hi, prev_lo -> hi, lo).
//   - It computes the 64-bit result, including the divide-by-zero hold.
//   - The top module holds cnt, busy, pending, HI, LO and the result mux.
// TESTING
// - Reset, then MFHI/MFLO -> mdu_result=0. busy=0 throughout.
// - MULT A=0xFFFFFFFF B=2 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
//   MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
// - DIV A=0xFFFFFFF9 (-7) B=2 -> busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//   DIVU A=7 B=2 -> LO=3, HI=1.
//   DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
// - MTHI 0x1234 and MTLO 0xABCD at idle, then DIV by B=0 -> busy 10 cycles; HI=0x1234, LO=0xABCD unchanged.
// - During MULT busy, assert DIV start and MTLO 0x5555 -> both ignored.
//   Busy falls on schedule and HI/LO hold the MULT result only.
// - DIV started, reset asserted on 4th busy cycle -> next cycle busy=0, HI=0, LO=0. No late commit occurs.

Source files
------------

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared definitions for the multiply/divide unit.
//   - mdu_op_e : 4-bit MD operation encodings, shared with decode and hazard control
//   - mdu_is_start() : true for ops that launch a multi-cycle operation
package md_unit_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_e;

    function automatic logic mdu_is_start(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic mdu_is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_calc.sv
// md_calc: combinational 64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU.
//   op      in  4   MD operation
//   a, b    in  32  multiplicand/dividend, multiplier/divisor
//   prev_hi in  32  current HI (held on divide by zero / non-arith op)
//   prev_lo in  32  current LO
//   hi, lo  out 32  result
module md_calc
    import md_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] prev_hi,
    input  logic [31:0] prev_lo,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_sdiv_b;
    logic [31:0] w_udiv_b;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic        w_b_zero;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide on magnitudes: quotient sign = sign(a)^sign(b), remainder
    // takes the dividend's sign. 0x80000000/-1 falls out naturally: the
    // magnitude 0x80000000 negates back to itself.
    assign w_abs_a  = a[31] ? -a : a;
    assign w_abs_b  = b[31] ? -b : b;
    assign w_b_zero = (b == 32'd0);
    // Divisor forced to 1 when zero; that result is discarded anyway.
    assign w_sdiv_b = w_b_zero ? 32'd1 : w_abs_b;
    assign w_udiv_b = w_b_zero ? 32'd1 : b;
    assign w_sq_mag = w_abs_a / w_sdiv_b;
    assign w_sr_mag = w_abs_a % w_sdiv_b;
    assign w_uq     = a / w_udiv_b;
    assign w_ur     = a % w_udiv_b;

    always_comb begin
        hi = prev_hi;
        lo = prev_lo;
        case (op)
            MDU_MULT:  {hi, lo} = w_prod_s;
            MDU_MULTU: {hi, lo} = w_prod_u;
            MDU_DIV: if (!w_b_zero) begin
                lo = (a[31] ^ b[31]) ? -w_sq_mag : w_sq_mag;
                hi = a[31] ? -w_sr_mag : w_sr_mag;
            end
            MDU_DIVU: if (!w_b_zero) begin
                lo = w_uq;
                hi = w_ur;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit owning HI/LO.
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   valid           : EX instruction is real; qualifies every op
//   mdu_op          : MD operation (md_unit_pkg::mdu_op_e)
//   SrcA, SrcB      : rs/rt operands
//   busy            : multi-cycle op in flight (hazard control stalls MD ops)
//   HI, LO          : architectural HI/LO
//   mdu_result      : MFHI -> HI, MFLO -> LO, else 0 (combinational)
// Result is computed at start and parked in pending regs; HI/LO update on
// the last busy edge so busy is high for exactly MULT_CYCLES/DIV_CYCLES.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] mdu_result
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    mdu_state_e  r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [31:0] r_pend_hi, w_pend_hi;
    logic [31:0] r_pend_lo, w_pend_lo;
    logic [31:0] r_hi, w_hi;
    logic [31:0] r_lo, w_lo;
    logic [31:0] w_calc_hi;
    logic [31:0] w_calc_lo;
    logic        w_start;

    md_calc u_calc (
        .op      (mdu_op),
        .a       (SrcA),
        .b       (SrcB),
        .prev_hi (r_hi),
        .prev_lo (r_lo),
        .hi      (w_calc_hi),
        .lo      (w_calc_lo)
    );

    assign w_start = valid && (r_state == S_IDLE) && mdu_is_start(mdu_op);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_pend_hi <= w_pend_hi;
            r_pend_lo <= w_pend_lo;
            r_hi      <= w_hi;
            r_lo      <= w_lo;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_pend_hi = r_pend_hi;
        w_pend_lo = r_pend_lo;
        w_hi      = r_hi;
        w_lo      = r_lo;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_pend_hi = w_calc_hi;
                    w_pend_lo = w_calc_lo;
                    w_cnt     = mdu_is_div(mdu_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    w_state   = S_BUSY;
                end else if (valid && mdu_op == MDU_MTHI) begin
                    w_hi = SrcA;
                end else if (valid && mdu_op == MDU_MTLO) begin
                    w_lo = SrcA;
                end
            end
            S_BUSY: begin
                // Any op arriving here is dropped; hazard control must stall it.
                if (r_cnt <= CW'(1)) begin
                    w_hi    = r_pend_hi;
                    w_lo    = r_pend_lo;
                    w_cnt   = '0;
                    w_state = S_IDLE;
                end else begin
                    w_cnt = r_cnt - CW'(1);
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign busy = (r_state == S_BUSY);
    assign HI   = r_hi;
    assign LO   = r_lo;

    always_comb begin
        mdu_result = 32'd0;
        if (mdu_op == MDU_MFHI)      mdu_result = r_hi;
        else if (mdu_op == MDU_MFLO) mdu_result = r_lo;
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed + randomized checks of md_unit against an arithmetic
// reference model (64-bit longint multiply/divide) of HI/LO.
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid = 1'b0;
    logic [3:0]  mdu_op = MDU_NONE;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] mdu_result;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid),
        .mdu_op     (mdu_op),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .busy       (busy),
        .HI         (HI),
        .LO         (LO),
        .mdu_result (mdu_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: architectural {HI,LO} after an op, from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
        longint q, r, p;
        longint unsigned pu;
        logic [63:0] res;
        res = {hi, lo};
        case (op)
            MDU_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                res = p;
            end
            MDU_MULTU: begin
                pu = longint'({32'd0, a}) * longint'({32'd0, b});
                res = pu;
            end
            MDU_DIV: if (b != 0) begin
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                res = {r[31:0], q[31:0]};
            end
            MDU_DIVU: if (b != 0) res = {a % b, a / b};
            MDU_MTHI: res = {a, lo};
            MDU_MTLO: res = {hi, a};
            default: ;
        endcase
        return res;
    endfunction

    // One-cycle op issue; returns at the negedge after the sampling edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        valid = 1'b1; mdu_op = op; SrcA = a; SrcB = b;
        @(negedge clk);
        valid = 1'b0; mdu_op = MDU_NONE;
    endtask

    task automatic busy_len(input string tag, input int exp_n);
        int c = 0;
        while (busy === 1'b1 && c < 100) begin
            c++;
            @(negedge clk);
        end
        chk(tag, 32'(c), 32'(exp_n));
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".HI"}, HI, m_hi);
        chk({tag, ".LO"}, LO, m_lo);
        mdu_op = MDU_MFHI; #1;
        chk({tag, ".MFHI"}, mdu_result, m_hi);
        mdu_op = MDU_MFLO; #1;
        chk({tag, ".MFLO"}, mdu_result, m_lo);
        mdu_op = MDU_NONE; #1;
        chk({tag, ".NONE"}, mdu_result, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] nx;
        nx = ref_md(op, a, b, m_hi, m_lo);
        issue(op, a, b);
        if (mdu_is_start(op)) busy_len({tag, ".busy"}, mdu_is_div(op) ? DC : MC);
        else chk({tag, ".nobusy"}, 32'(busy), 32'd0);
        {m_hi, m_lo} = nx;
        check_regs(tag);
    endtask

    initial begin
        int bc;
        logic [3:0] op;
        logic [31:0] a, b;

        // Reset
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst.busy", 32'(busy), 32'd0);
        check_regs("rst");

        // Directed arithmetic
        run_op("mult",  MDU_MULT,  32'hFFFFFFFF, 32'd2);
        chk("mult.k.HI", HI, 32'hFFFFFFFF);
        chk("mult.k.LO", LO, 32'hFFFFFFFE);
        run_op("multu", MDU_MULTU, 32'hFFFFFFFF, 32'd2);
        chk("multu.k.HI", HI, 32'h00000001);
        chk("multu.k.LO", LO, 32'hFFFFFFFE);
        run_op("div",   MDU_DIV,   32'hFFFFFFF9, 32'd2);
        chk("div.k.LO", LO, 32'hFFFFFFFD);
        chk("div.k.HI", HI, 32'hFFFFFFFF);
        run_op("divu",  MDU_DIVU,  32'd7, 32'd2);
        chk("divu.k.LO", LO, 32'd3);
        chk("divu.k.HI", HI, 32'd1);
        run_op("divovf", MDU_DIV,  32'h80000000, 32'hFFFFFFFF);
        chk("divovf.k.LO", LO, 32'h80000000);
        chk("divovf.k.HI", HI, 32'd0);

        // MTHI/MTLO then divide by zero holds them
        run_op("mthi", MDU_MTHI, 32'h1234, 32'd0);
        run_op("mtlo", MDU_MTLO, 32'hABCD, 32'd0);
        run_op("div0", MDU_DIV,  32'd99, 32'd0);
        chk("div0.k.HI", HI, 32'h1234);
        chk("div0.k.LO", LO, 32'hABCD);
        run_op("divu0", MDU_DIVU, 32'd5, 32'd0);

        // Ops presented while busy are dropped
        @(negedge clk);
        valid = 1'b1; mdu_op = MDU_MULT; SrcA = 32'd6; SrcB = 32'hFFFFFFFD;
        bc = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (busy === 1'b1) bc++;
            case (i)
                0: begin valid = 1'b1; mdu_op = MDU_DIV;  SrcA = 32'd100;   SrcB = 32'd3; end
                1: begin valid = 1'b1; mdu_op = MDU_MTLO; SrcA = 32'h5555; end
                default: begin valid = 1'b0; mdu_op = MDU_NONE; end
            endcase
        end
        chk("ovl.busy", 32'(bc), 32'(MC));
        m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFEE;  // 6 * -3 = -18
        check_regs("ovl");

        // Randomized ops
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 5))
                0: op = MDU_MULT;
                1: op = MDU_MULTU;
                2: op = MDU_DIV;
                3: op = MDU_DIVU;
                4: op = MDU_MTHI;
                default: op = MDU_MTLO;
            endcase
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: b = -32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op($sformatf("rnd%0d", k), op, a, b);
        end

        // Reset during a DIV: no late commit
        run_op("pre", MDU_MTHI, 32'hDEAD, 32'd0);
        issue(MDU_DIV, 32'd7, 32'd2);           // now in busy cycle 1
        repeat (3) @(negedge clk);              // busy cycle 4
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        chk("rstmid.busy", 32'(busy), 32'd0);
        check_regs("rstmid");
        repeat (DC + 2) @(negedge clk);
        chk("rstmid.late.busy", 32'(busy), 32'd0);
        check_regs("rstmid.late");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
